// File: rtl/ysyx_22040895_mdu_seq.sv
// Sequential multiply/divide unit for an RV64 pipeline.
// MUL/MULW use a 1-bit/cycle shift-add datapath; DIVW/REMW use 32-iteration
// restoring division on operand magnitudes with a sign fix-up at the end.
// Three states: IDLE accepts a request, CALC iterates, DONE pulses the result.
module ysyx_22040895_mdu_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i_mdu,
  input  logic [3:0]  mduop_i_mdu,
  input  logic [63:0] src1_i_mdu,
  input  logic [63:0] src2_i_mdu,
  input  logic        flush_i_mdu,
  output logic        ready_o_mdu,
  output logic        busy_o_mdu,
  output logic        done_o_mdu,
  output logic [63:0] result_o_mdu
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Operation kind is taken straight from mduop[3:2] once mduop[1:0] == 2'b01.
  typedef enum logic [1:0] {
    OP_MUL  = 2'b00,
    OP_MULW = 2'b01,
    OP_DIVW = 2'b10,
    OP_REMW = 2'b11
  } op_t;

  state_t      state;
  op_t         op_q;
  logic [6:0]  cnt;
  // MUL: acc = partial product, mcand = shifted multiplicand, mplier = shifted multiplier.
  // DIV: acc = partial remainder, mcand = |divisor|, mplier = dividend shifting out / quotient shifting in.
  logic [63:0] acc;
  logic [63:0] mcand;
  logic [63:0] mplier;
  logic        neg_q;
  logic        neg_r;
  logic        div_zero;
  logic [31:0] dividend_lo;

  logic        legal;
  logic        accept;
  op_t         op_in;
  logic [31:0] abs1;
  logic [31:0] abs2;

  logic [63:0] acc_nxt;
  logic [63:0] mcand_nxt;
  logic [63:0] mplier_nxt;
  logic [32:0] rem_shift;
  logic [32:0] rem_new;
  logic [31:0] q_s;
  logic [31:0] r_s;
  logic [63:0] final_result;

  function automatic logic [63:0] sext32(input logic [31:0] x);
    return {{32{x[31]}}, x};
  endfunction

  assign legal  = (mduop_i_mdu[1:0] == 2'b01);
  assign op_in  = op_t'(mduop_i_mdu[3:2]);
  assign accept = (state == IDLE) && valid_i_mdu && legal && !flush_i_mdu;
  assign abs1   = src1_i_mdu[31] ? (32'd0 - src1_i_mdu[31:0]) : src1_i_mdu[31:0];
  assign abs2   = src2_i_mdu[31] ? (32'd0 - src2_i_mdu[31:0]) : src2_i_mdu[31:0];

  // Stall request: raised in the accept cycle itself and throughout CALC, dropped in DONE.
  assign busy_o_mdu = accept || (state == CALC);

  // One iteration of the selected datapath plus the result it would finalise to.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    acc_nxt      = acc;
    mcand_nxt    = mcand;
    mplier_nxt   = mplier;
    rem_shift    = {acc[31:0], mplier[31]};
    rem_new      = rem_shift;
    q_s          = 32'd0;
    r_s          = 32'd0;
    final_result = 64'd0;
    if (op_q == OP_MUL || op_q == OP_MULW) begin
      acc_nxt    = mplier[0] ? (acc + mcand) : acc;
      mcand_nxt  = {mcand[62:0], 1'b0};
      mplier_nxt = {1'b0, mplier[63:1]};
    end else begin
      if (rem_shift >= {1'b0, mcand[31:0]}) begin
        rem_new    = rem_shift - {1'b0, mcand[31:0]};
        mplier_nxt = {32'd0, mplier[30:0], 1'b1};
      end else begin
        mplier_nxt = {32'd0, mplier[30:0], 1'b0};
      end
      acc_nxt = {31'd0, rem_new};
    end
    // The 0x80000000 / -1 overflow case needs no special path: the magnitude
    // quotient 0x80000000 negates to itself and the remainder is zero.
    q_s = neg_q ? (32'd0 - mplier_nxt[31:0]) : mplier_nxt[31:0];
    r_s = neg_r ? (32'd0 - acc_nxt[31:0]) : acc_nxt[31:0];
    unique case (op_q)
      OP_MUL:  final_result = acc_nxt;
      OP_MULW: final_result = sext32(acc_nxt[31:0]);
      OP_DIVW: final_result = div_zero ? 64'hFFFF_FFFF_FFFF_FFFF : sext32(q_s);
      OP_REMW: final_result = div_zero ? sext32(dividend_lo) : sext32(r_s);
      default: final_result = 64'd0;
    endcase
  end

  // Control FSM with registered outputs and the iterating datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: datapath registers are reset too, so a discarded operation can never leak into a later result.
    if (!rst) begin
      state        <= IDLE;
      op_q         <= OP_MUL;
      cnt          <= 7'd0;
      acc          <= 64'd0;
      mcand        <= 64'd0;
      mplier       <= 64'd0;
      neg_q        <= 1'b0;
      neg_r        <= 1'b0;
      div_zero     <= 1'b0;
      dividend_lo  <= 32'd0;
      result_o_mdu <= 64'd0;
      done_o_mdu   <= 1'b0;
      ready_o_mdu  <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      done_o_mdu <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            state       <= CALC;
            ready_o_mdu <= 1'b0;
            op_q        <= op_in;
            acc         <= 64'd0;
            neg_q       <= src1_i_mdu[31] ^ src2_i_mdu[31];
            neg_r       <= src1_i_mdu[31];
            div_zero    <= (src2_i_mdu[31:0] == 32'd0);
            dividend_lo <= src1_i_mdu[31:0];
            unique case (op_in)
              OP_MUL: begin
                cnt    <= 7'd64;
                mcand  <= src1_i_mdu;
                mplier <= src2_i_mdu;
              end
              OP_MULW: begin
                cnt    <= 7'd32;
                mcand  <= {32'd0, src1_i_mdu[31:0]};
                mplier <= {32'd0, src2_i_mdu[31:0]};
              end
              default: begin
                cnt    <= 7'd32;
                mcand  <= {32'd0, abs2};
                mplier <= {32'd0, abs1};
              end
            endcase
          end
        end
        CALC: begin
          if (flush_i_mdu) begin
            state       <= IDLE;
            ready_o_mdu <= 1'b1;
          end else begin
            acc    <= acc_nxt;
            mcand  <= mcand_nxt;
            mplier <= mplier_nxt;
            cnt    <= cnt - 7'd1;
            if (cnt == 7'd1) begin
              state        <= DONE;
              result_o_mdu <= final_result;
              done_o_mdu   <= 1'b1;
            end
          end
        end
        DONE: begin
          state       <= IDLE;
          ready_o_mdu <= 1'b1;
        end
        default: begin
          state       <= IDLE;
          ready_o_mdu <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/ysyx_22040895_mdu_seq.md
YSYX_22040895_MDU_SEQ -- requirements
Module: ysyx_22040895_mdu_seq

Interface
REQ-001 SHALL have one clock and one reset: reset is asynchronous and active-low.
REQ-002 SHALL provide port: clk  in  1  rising-edge clock.
REQ-003 SHALL provide port: rst  in  1  asynchronous active-low reset.
REQ-004 SHALL provide port: valid_i_mdu  in  1  request valid from the decode/execute stage.
REQ-005 SHALL provide port: mduop_i_mdu  in  4  operation select; 0001 MUL, 0101 MULW, 1001 DIVW, 1101 REMW; all other codes illegal.
REQ-006 SHALL provide port: src1_i_mdu  in  64  rs1 operand (multiplicand/dividend).
REQ-007 SHALL provide port: src2_i_mdu  in  64  rs2 operand (multiplier/divisor).
REQ-008 SHALL provide port: flush_i_mdu  in  1  abort the in-flight operation.
REQ-009 SHALL provide port: ready_o_mdu  out  1  high in IDLE (can accept).
REQ-010 SHALL provide port: busy_o_mdu  out  1  pipeline stall request.
REQ-011 SHALL provide port: done_o_mdu  out  1  one-cycle result-valid pulse.
REQ-012 SHALL provide port: result_o_mdu  out  64  registered result.

Function
REQ-013 SHALL implement FSM states IDLE, CALC, DONE.
REQ-014 Accept SHALL occur when state=IDLE, valid_i_mdu=1, mduop legal and flush_i_mdu=0; operands and op are latched and state goes to CALC.
REQ-015 Illegal mduop with valid_i_mdu=1 SHALL be ignored: no state change, no done, busy_o_mdu=0.
REQ-016 Iteration counter SHALL load N on accept (N=64 for MUL, 32 for MULW/DIVW/REMW) and decrement once per CALC cycle; CALC→DONE when the counter reaches 1 and decrements.
REQ-017 Latency: with accept in cycle t, DONE SHALL be cycle t+N+1, done_o_mdu=1 for exactly that cycle, then IDLE at t+N+2.
REQ-018 busy_o_mdu SHALL equal (IDLE & accept) | CALC, combinationally; it SHALL be 0 in DONE so the pipeline captures the result that cycle.
REQ-019 ready_o_mdu SHALL be 1 only in IDLE.
REQ-020 MUL SHALL use a 1-bit/cycle shift-add datapath and produce the low 64 bits of src1*src2 (sign-agnostic).
REQ-021 MULW SHALL produce the low 32 bits of src1[31:0]*src2[31:0], sign-extended to 64.
REQ-022 DIVW/REMW SHALL use 32-iteration restoring division on |src1[31:0]| and |src2[31:0]|; quotient negated if the operand signs differ; remainder takes the dividend sign; results sign-extended to 64.
REQ-023 Divide-by-zero: DIVW SHALL return 0xFFFFFFFFFFFFFFFF; REMW SHALL return sext(src1[31:0]); full latency is still taken.
REQ-024 Overflow (src1[31:0]=0x80000000, src2[31:0]=0xFFFFFFFF): DIVW SHALL return 0xFFFFFFFF80000000; REMW SHALL return 0; full latency is still taken.
REQ-025 result_o_mdu SHALL update only on the CALC→DONE transition and SHALL hold until the next completion.
REQ-026 valid_i_mdu SHALL be ignored in CALC and DONE (no queuing).
REQ-027 flush_i_mdu=1 in CALC or DONE SHALL force IDLE next cycle; done_o_mdu=0 in that cycle and result_o_mdu is unchanged.
REQ-028 flush_i_mdu=1 in IDLE concurrent with valid_i_mdu SHALL block the accept (flush wins) and SHALL force busy_o_mdu=0.
REQ-029 A legal request in the cycle after DONE SHALL be accepted normally (back-to-back operation).

Reset
REQ-030 On rst=0, regardless of clk: state=IDLE, counter=0, result_o_mdu=0, done_o_mdu=0, ready_o_mdu=1, busy_o_mdu=0.
REQ-031 Reset asserted mid-CALC SHALL discard the operation with no done pulse after release.
REQ-032 First accept SHALL be possible on the first rising edge after rst deasserts.

Verification
REQ-033 MUL src1=3, src2=0xFFFFFFFFFFFFFFFB → result 0xFFFFFFFFFFFFFFF1; done at t+65; busy high t..t+64.
REQ-034 MULW src1=0x40000000, src2=2 → 0xFFFFFFFF80000000 at t+33; MULW src1=0x80000000, src2=2 → 0.
REQ-035 DIVW -7/2 → 0xFFFFFFFFFFFFFFFD; REMW -7%2 → 0xFFFFFFFFFFFFFFFF; both done at t+33.
REQ-036 DIVW 5/0 → all ones; REMW 5/0 → 5; DIVW 0x80000000/0xFFFFFFFF → 0xFFFFFFFF80000000; REMW of the same → 0.
REQ-037 Flush in the 10th CALC cycle → IDLE next cycle, no done pulse, result unchanged; a new MUL accepted the following cycle completes correctly.
REQ-038 rst=0 mid-CALC → all outputs reach reset values asynchronously; no done pulse after release; illegal mduop 0011 with valid → ignored, ready stays 1.
